// File: rtl/compressed_fetch_sequencer_pkg.sv
// Shared definitions for the compressed fetch sequencer: reset PC default,
// word buffer geometry and the buffer control encoding.
package compressed_fetch_sequencer_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int FETCH_BUF_DEPTH  = 2;
    localparam int FETCH_WORD_WIDTH = 32;
    localparam int FETCH_PTR_W      = (FETCH_BUF_DEPTH > 1) ? $clog2(FETCH_BUF_DEPTH) : 1;
    localparam int FETCH_CNT_W      = $clog2(FETCH_BUF_DEPTH + 1);
    localparam logic [FETCH_CNT_W-1:0] FETCH_FULL_CNT = FETCH_CNT_W'(FETCH_BUF_DEPTH);

    // Encoded as {push, pop} so the buffer can cast its qualified strobes directly.
    typedef enum logic [1:0] {
        FIFO_IDLE     = 2'b00,
        FIFO_POP      = 2'b01,
        FIFO_PUSH     = 2'b10,
        FIFO_PUSH_POP = 2'b11
    } fifo_op_e;

    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } parcel_half_e;

    function automatic logic [15:0] selectParcel(input logic [31:0] word, input parcel_half_e half);
        return (half == HALF_HI) ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/compressed_fetch_sequencer_fifo.sv
// Small word buffer between instruction memory and the parcel issue stage;
// supports simultaneous push/pop and a single-cycle flush.
module fetch_word_fifo
    import compressed_fetch_sequencer_pkg::*;
(
    input  logic                        clk,
    input  logic                        i_rst,
    input  logic                        i_flush,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [FETCH_WORD_WIDTH-1:0] i_wrData,
    output logic [FETCH_WORD_WIDTH-1:0] o_headData,
    output logic [FETCH_CNT_W-1:0]      o_count
);

    logic [FETCH_WORD_WIDTH-1:0] r_mem [FETCH_BUF_DEPTH];
    logic [FETCH_PTR_W-1:0]      r_rdPtr;
    logic [FETCH_PTR_W-1:0]      r_wrPtr;
    logic [FETCH_CNT_W-1:0]      r_count;

    logic     w_full;
    logic     w_empty;
    logic     w_doPush;
    logic     w_doPop;
    fifo_op_e w_op;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    always_comb begin
        w_full   = (r_count == FETCH_FULL_CNT);
        w_empty  = (r_count == '0);
        w_doPop  = i_pop & ~w_empty;
        w_doPush = i_push & (~w_full | w_doPop);
        w_op     = fifo_op_e'({w_doPush, w_doPop});
    end

    always_ff @(posedge clk) begin
        if (i_rst || i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            case (w_op)
                FIFO_PUSH: begin
                    r_wrPtr <= r_wrPtr + 1'b1;
                    r_count <= r_count + 1'b1;
                end
                FIFO_POP: begin
                    r_rdPtr <= r_rdPtr + 1'b1;
                    r_count <= r_count - 1'b1;
                end
                FIFO_PUSH_POP: begin
                    r_wrPtr <= r_wrPtr + 1'b1;
                    r_rdPtr <= r_rdPtr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush && !i_rst && !i_flush) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    assign o_headData = r_mem[r_rdPtr];
    assign o_count    = r_count;

endmodule

// File: rtl/compressed_fetch_sequencer.sv
// Fetches 32-bit words ahead of the core and issues 16-bit compressed parcels
// one per cycle, handling redirects to halfword-aligned targets.
module compressed_fetch_sequencer
    import compressed_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [15:0] InstOut,
    output logic        InstValid,
    output logic [31:0] InstPC,
    input  logic        InstReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC
);

    localparam logic [31:0] RESET_ISSUE_PC = {RESET_PC[31:1], 1'b0};

    logic [29:0] r_fetchAddr;
    logic [31:0] r_issuePc;

    logic [FETCH_WORD_WIDTH-1:0] w_headWord;
    logic [FETCH_CNT_W-1:0]      w_count;
    logic [31:0]                 w_redirectTarget;
    logic                        w_imemReq;
    logic                        w_push;
    logic                        w_instValid;
    logic                        w_accept;
    logic                        w_pop;
    logic                        w_unusedRedirectLsb;

    // Redirect outranks everything but reset: it blocks the push and the accept of its own cycle.
    always_comb begin
        w_redirectTarget    = {RedirectPC[31:1], 1'b0};
        w_unusedRedirectLsb = RedirectPC[0];
        w_imemReq           = (w_count < FETCH_FULL_CNT) & ~rst;
        w_push              = w_imemReq & ImemAck & ~Redirect;
        w_instValid         = (w_count != '0) & ~Redirect & ~rst;
        w_accept            = w_instValid & InstReady;
        w_pop               = w_accept & r_issuePc[1];
    end

    fetch_word_fifo u_wordFifo (
        .clk        (clk),
        .i_rst      (rst),
        .i_flush    (Redirect),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_wrData   (ImemData),
        .o_headData (w_headWord),
        .o_count    (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issuePc   <= RESET_ISSUE_PC;
            r_fetchAddr <= RESET_PC[31:2];
        end else if (Redirect) begin
            r_issuePc   <= w_redirectTarget;
            r_fetchAddr <= w_redirectTarget[31:2];
        end else begin
            if (w_push) begin
                r_fetchAddr <= r_fetchAddr + 30'd1;
            end
            if (w_accept) begin
                r_issuePc <= r_issuePc + 32'd2;
            end
        end
    end

    assign ImemReq   = w_imemReq;
    assign ImemAddr  = {r_fetchAddr, 2'b00};
    assign InstValid = w_instValid;
    assign InstPC    = r_issuePc;
    assign InstOut   = w_instValid ? selectParcel(w_headWord, parcel_half_e'(r_issuePc[1])) : 16'h0000;

endmodule

// File: tb/tb_compressed_fetch_sequencer.sv
// Scoreboard bench: the expected parcel stream is derived from the memory image
// and the last restart point; a negedge monitor checks every accepted parcel.
module tb_compressed_fetch_sequencer;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, ImemAck, InstReady, Redirect;
    logic [31:0] RedirectPC, ImemData, ImemAddr, InstPC;
    logic        ImemReq, InstValid;
    logic [15:0] InstOut;

    logic        rst2, ImemReq2, InstValid2;
    logic [31:0] ImemAddr2, ImemData2, InstPC2;
    logic [15:0] InstOut2;

    exp_t expQ[$];
    logic [31:0] genPc;
    int testsRun = 0;
    int failures = 0;
    int acceptCount = 0;

    always #5 clk = ~clk;

    compressed_fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck),
        .ImemData(ImemData), .InstOut(InstOut), .InstValid(InstValid), .InstPC(InstPC),
        .InstReady(InstReady), .Redirect(Redirect), .RedirectPC(RedirectPC)
    );

    compressed_fetch_sequencer #(.RESET_PC(RESET_PC2)) dut2 (
        .clk(clk), .rst(rst2), .ImemReq(ImemReq2), .ImemAddr(ImemAddr2), .ImemAck(1'b1),
        .ImemData(ImemData2), .InstOut(InstOut2), .InstValid(InstValid2), .InstPC(InstPC2),
        .InstReady(1'b1), .Redirect(1'b0), .RedirectPC(32'h0)
    );

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'h0) return 32'hBBBB_AAAA;
        return (addr * 32'h9E37_79B1) ^ 32'hC3A5_5A3C ^ {addr[15:0], addr[31:16]};
    endfunction

    function automatic logic [15:0] expectedParcel(input logic [31:0] pc);
        logic [31:0] word;
        word = memWord({pc[31:2], 2'b00});
        return pc[1] ? word[31:16] : word[15:0];
    endfunction

    always_comb ImemData  = ImemAck ? memWord(ImemAddr) : 32'hDEAD_BEEF;
    always_comb ImemData2 = memWord(ImemAddr2);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs and restarts the expected stream whenever the design must restart.
    task automatic applyStimulus(input logic rstV, input logic ackV, input logic readyV,
                                 input logic redirV, input logic [31:0] redirPcV);
        @(posedge clk);
        #1;
        rst        = rstV;
        ImemAck    = ackV;
        InstReady  = readyV;
        Redirect   = redirV;
        RedirectPC = redirPcV;
        if (rstV) begin
            expQ.delete();
            genPc = {RESET_PC[31:1], 1'b0};
        end else if (redirV) begin
            expQ.delete();
            genPc = {redirPcV[31:1], 1'b0};
        end
        while (expQ.size() < 4) begin
            expQ.push_back('{pc: genPc, inst: expectedParcel(genPc)});
            genPc = genPc + 32'd2;
        end
    endtask

    initial begin
        logic        prevRst;
        logic        holdValid;
        logic [31:0] holdPc;
        logic [15:0] holdInst;
        exp_t        e;
        prevRst   = 1'b1;
        holdValid = 1'b0;
        holdPc    = '0;
        holdInst  = '0;
        forever begin
            @(negedge clk);
            checkOutput("addr_align", {30'b0, ImemAddr[1:0]}, 32'd0);
            if (rst) begin
                checkOutput("req_in_reset", 32'(ImemReq), 32'd0);
                checkOutput("valid_in_reset", 32'(InstValid), 32'd0);
            end else if (prevRst) begin
                checkOutput("valid_after_reset", 32'(InstValid), 32'd0);
                checkOutput("pc_after_reset", InstPC, RESET_PC);
                checkOutput("req_after_reset", 32'(ImemReq), 32'd1);
            end
            if (holdValid && !rst && !Redirect) begin
                checkOutput("stall_valid", 32'(InstValid), 32'd1);
                checkOutput("stall_pc", InstPC, holdPc);
                checkOutput("stall_inst", 32'(InstOut), 32'(holdInst));
            end
            holdValid = InstValid && !InstReady && !rst;
            holdPc    = InstPC;
            holdInst  = InstOut;
            if (InstValid && InstReady) begin
                acceptCount++;
                if (expQ.size() == 0) begin
                    testsRun++;
                    failures++;
                    $display("[TB] FAIL unexpected_parcel: got pc %h inst %h expected none", InstPC, InstOut);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("parcel_pc", InstPC, e.pc);
                    checkOutput("parcel_inst", 32'(InstOut), 32'(e.inst));
                end
            end
            prevRst = rst;
        end
    end

    initial begin
        int base;
        logic [31:0] wrapPcs [3];
        rst = 1'b1; ImemAck = 1'b0; InstReady = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        rst2 = 1'b1;
        genPc = RESET_PC;
        wrapPcs[0] = 32'hFFFF_FFFC;
        wrapPcs[1] = 32'hFFFF_FFFE;
        wrapPcs[2] = 32'h0000_0000;

        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 20 && acceptCount < 1; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("first_parcel_seen", 32'(acceptCount >= 1), 32'd1);

        // Stall right after the first parcel: the buffer tops out at two words.
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("stall_req_drop", 32'(ImemReq), 32'd0);
        checkOutput("stall_addr", ImemAddr, 32'h0000_0008);
        base = acceptCount;
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("throughput", 32'(acceptCount - base), 32'd10);

        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0106);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("redir_addr0", ImemAddr, 32'h0000_0104);
        checkOutput("redir_gap_valid", 32'(InstValid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("redir_addr1", ImemAddr, 32'h0000_0108);
        checkOutput("redir_pc", InstPC, 32'h0000_0106);

        repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0301);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("redir_ack_addr", ImemAddr, 32'h0000_0300);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("rst_stall_pc", InstPC, RESET_PC);
        checkOutput("rst_stall_valid", 32'(InstValid), 32'd0);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        base = acceptCount;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom % 200) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
                          ($urandom % 20) == 0, $urandom);
        end
        @(negedge clk);
        #1;
        checkOutput("random_progress", 32'((acceptCount - base) > 600), 32'd1);

        // Second instance: sequential run across the top of the address space.
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        @(negedge clk);
        checkOutput("wrap_first_addr", ImemAddr2, 32'hFFFF_FFFC);
        checkOutput("wrap_first_req", 32'(ImemReq2), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) checkOutput("wrap_addr_zero", ImemAddr2, 32'h0000_0000);
            checkOutput("wrap_valid", 32'(InstValid2), 32'd1);
            checkOutput("wrap_pc", InstPC2, wrapPcs[i]);
            checkOutput("wrap_inst", 32'(InstOut2), 32'(expectedParcel(wrapPcs[i])));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
